// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared state encoding and port indices for the memory arbiter.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int PORT_IFU = 0;
    localparam int PORT_LSU = 1;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin pick; on a tie the port equal to prio wins.
module rr_arb2
    import mem_arbiter_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       prio_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o = req_i;
        if (&req_i) gnt_o = prio_i ? 2'b10 : 2'b01;
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one downstream memory port between the I-cache (port 0) and D-cache (port 1),
// one transaction outstanding, round-robin grant, request fields latched on acceptance.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_W-1:0]     s0_addr,
    input  logic                  s0_avalid,
    output logic                  s0_aready,
    input  logic [DATA_W-1:0]     s0_wdata,
    input  logic [DATA_W/8-1:0]   s0_wstrb,
    output logic [DATA_W-1:0]     s0_rdata,
    output logic                  s0_bvalid,
    input  logic                  s0_bready,
    input  logic [ADDR_W-1:0]     s1_addr,
    input  logic                  s1_avalid,
    output logic                  s1_aready,
    input  logic [DATA_W-1:0]     s1_wdata,
    input  logic [DATA_W/8-1:0]   s1_wstrb,
    output logic [DATA_W-1:0]     s1_rdata,
    output logic                  s1_bvalid,
    input  logic                  s1_bready,
    output logic [ADDR_W-1:0]     m_addr,
    output logic                  m_avalid,
    input  logic                  m_aready,
    output logic [DATA_W-1:0]     m_wdata,
    output logic [DATA_W/8-1:0]   m_wstrb,
    input  logic [DATA_W-1:0]     m_rdata,
    input  logic                  m_bvalid,
    output logic                  m_bready,
    output logic                  busy
);

    state_e                state_q, state_d;
    logic                  prio_q, prio_d;
    logic                  gnt_q, gnt_d;
    logic [ADDR_W-1:0]     addr_q;
    logic [DATA_W-1:0]     wdata_q;
    logic [DATA_W/8-1:0]   wstrb_q;
    logic [1:0]            pick;
    logic                  idle, resp, take, sel_bready;

    rr_arb2 u_arb (
        .req_i  ({s1_avalid, s0_avalid}),
        .prio_i (prio_q),
        .gnt_o  (pick)
    );

    assign idle       = state_q == IDLE;
    assign resp       = state_q == RESP;
    // rst gates acceptance so no aready leaks out while reset is held
    assign take       = rst && idle && |pick;
    assign sel_bready = gnt_q ? s1_bready : s0_bready;

    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        gnt_d   = gnt_q;
        case (state_q)
            IDLE: if (take) begin
                state_d = REQ;
                gnt_d   = pick[PORT_LSU];
            end
            REQ: if (m_aready) state_d = RESP;
            RESP: if (m_bvalid && sel_bready) begin
                state_d = IDLE;
                prio_d  = ~gnt_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            prio_q  <= 1'b0;
            gnt_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            gnt_q   <= gnt_d;
            if (take) begin
                addr_q  <= pick[PORT_LSU] ? s1_addr  : s0_addr;
                wdata_q <= pick[PORT_LSU] ? s1_wdata : s0_wdata;
                wstrb_q <= pick[PORT_LSU] ? s1_wstrb : s0_wstrb;
            end
        end
    end

    assign s0_aready = take && pick[PORT_IFU];
    assign s1_aready = take && pick[PORT_LSU];
    assign m_addr    = addr_q;
    assign m_wdata   = wdata_q;
    assign m_wstrb   = wstrb_q;
    assign m_avalid  = state_q == REQ;
    assign m_bready  = resp && sel_bready;
    assign s0_bvalid = resp && !gnt_q && m_bvalid;
    assign s1_bvalid = resp && gnt_q && m_bvalid;
    assign s0_rdata  = (resp && !gnt_q) ? m_rdata : '0;
    assign s1_rdata  = (resp && gnt_q) ? m_rdata : '0;
    assign busy      = !idle;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized requesters and downstream memory checked against a transaction-level model.
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 64;
    localparam int SW = DW / 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [1:0][AW-1:0] s_addr;
    logic [1:0][DW-1:0] s_wdata;
    logic [1:0][SW-1:0] s_wstrb;
    logic [1:0]         s_avalid, s_bready;
    wire  [1:0]         s_aready, s_bvalid;
    wire  [1:0][DW-1:0] s_rdata;
    wire  [AW-1:0]      m_addr;
    wire  [DW-1:0]      m_wdata;
    wire  [SW-1:0]      m_wstrb;
    wire                m_avalid, m_bready, busy;
    logic               m_aready, m_bvalid;
    logic [DW-1:0]      m_rdata;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .s0_addr   (s_addr[0]),
        .s0_avalid (s_avalid[0]),
        .s0_aready (s_aready[0]),
        .s0_wdata  (s_wdata[0]),
        .s0_wstrb  (s_wstrb[0]),
        .s0_rdata  (s_rdata[0]),
        .s0_bvalid (s_bvalid[0]),
        .s0_bready (s_bready[0]),
        .s1_addr   (s_addr[1]),
        .s1_avalid (s_avalid[1]),
        .s1_aready (s_aready[1]),
        .s1_wdata  (s_wdata[1]),
        .s1_wstrb  (s_wstrb[1]),
        .s1_rdata  (s_rdata[1]),
        .s1_bvalid (s_bvalid[1]),
        .s1_bready (s_bready[1]),
        .m_addr    (m_addr),
        .m_avalid  (m_avalid),
        .m_aready  (m_aready),
        .m_wdata   (m_wdata),
        .m_wstrb   (m_wstrb),
        .m_rdata   (m_rdata),
        .m_bvalid  (m_bvalid),
        .m_bready  (m_bready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          v;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [SW-1:0] s;
    } req_t;

    req_t pend[2];
    req_t cur;
    int   cur_p, prio, mode, n_done;
    bit   inflight, acc_dn;
    int   grants[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_idle_outs(input string tag);
        chk({tag, "_aready"}, 64'(s_aready), 0);
        chk({tag, "_bvalid"}, 64'(s_bvalid), 0);
        chk({tag, "_busy"}, 64'(busy), 0);
        chk({tag, "_m_avalid"}, 64'(m_avalid), 0);
        chk({tag, "_m_bready"}, 64'(m_bready), 0);
        chk({tag, "_rdata0"}, s_rdata[0], 0);
        chk({tag, "_rdata1"}, s_rdata[1], 0);
        chk({tag, "_m_addr"}, 64'(m_addr), 0);
        chk({tag, "_m_wdata"}, m_wdata, 0);
        chk({tag, "_m_wstrb"}, 64'(m_wstrb), 0);
    endtask

    // Assert reset asynchronously (mid-cycle) with everything pushing, then release cleanly.
    task automatic go_reset(input string tag);
        rst = 1'b0;
        s_avalid = 2'b11;
        s_bready = 2'b11;
        m_aready = 1'b1;
        m_bvalid = 1'b1;
        #1;
        chk_idle_outs(tag);
        repeat (2) @(negedge clk);
        #1;
        chk_idle_outs({tag, "_held"});
        s_avalid = 2'b00;
        m_bvalid = 1'b0;
        rst = 1'b1;
        pend[0].v = 1'b0;
        pend[1].v = 1'b0;
        inflight = 1'b0;
        acc_dn = 1'b0;
        prio = 0;
        n_done = 0;
        grants.delete();
    endtask

    task automatic cycle();
        bit want[2];
        @(negedge clk);
        for (int p = 0; p < 2; p++) begin
            if (!pend[p].v && (mode == 2 || (mode == 1 && p == 0) || (mode == 0 && $urandom_range(0, 2) == 0))) begin
                pend[p].v = 1'b1;
                pend[p].a = $urandom;
                pend[p].d = {$urandom, $urandom};
                pend[p].s = $urandom_range(0, 1) ? '0 : SW'($urandom);
            end
            s_avalid[p] = pend[p].v;
            s_addr[p]   = pend[p].v ? pend[p].a : AW'($urandom);
            s_wdata[p]  = pend[p].v ? pend[p].d : {$urandom, $urandom};
            s_wstrb[p]  = pend[p].v ? pend[p].s : SW'($urandom);
            s_bready[p] = mode == 1 ? 1'b1 : ($urandom_range(0, 3) != 0);
        end
        m_aready = mode == 1 ? 1'b1 : 1'($urandom_range(0, 1));
        m_bvalid = acc_dn && (mode == 1 || $urandom_range(0, 2) != 0);
        m_rdata  = {$urandom, $urandom};
        #1;
        for (int p = 0; p < 2; p++)
            want[p] = !inflight && pend[p].v && (!pend[1-p].v || prio == p);
        chk("aready0", 64'(s_aready[0]), 64'(want[0]));
        chk("aready1", 64'(s_aready[1]), 64'(want[1]));
        chk("busy", 64'(busy), 64'(inflight));
        chk("m_avalid", 64'(m_avalid), 64'(inflight && !acc_dn));
        if (inflight) begin
            chk("m_addr", 64'(m_addr), 64'(cur.a));
            chk("m_wdata", m_wdata, cur.d);
            chk("m_wstrb", 64'(m_wstrb), 64'(cur.s));
        end
        for (int p = 0; p < 2; p++) begin
            chk($sformatf("bvalid%0d", p), 64'(s_bvalid[p]), 64'(inflight && acc_dn && cur_p == p && m_bvalid));
            chk($sformatf("rdata%0d", p), s_rdata[p], (inflight && acc_dn && cur_p == p) ? m_rdata : 64'd0);
        end
        chk("m_bready", 64'(m_bready), 64'(inflight && acc_dn && s_bready[cur_p]));
        if (s_bvalid[0] && s_bready[0]) n_done++;
        // Model advance for the coming rising edge
        if (!inflight) begin
            if (want[0] || want[1]) begin
                cur_p = want[0] ? 0 : 1;
                cur = pend[cur_p];
                pend[cur_p].v = 1'b0;
                inflight = 1'b1;
                acc_dn = 1'b0;
                grants.push_back(cur_p);
            end
        end else if (!acc_dn) begin
            if (m_aready) acc_dn = 1'b1;
        end else if (m_bvalid && s_bready[cur_p]) begin
            inflight = 1'b0;
            prio = 1 - cur_p;
        end
    endtask

    initial begin
        s_addr = '0;
        s_wdata = '0;
        s_wstrb = '0;
        m_rdata = '0;
        mode = 0;
        cur_p = 0;
        go_reset("reset");

        mode = 2;
        for (int i = 0; i < 400 && grants.size() < 4; i++) cycle();
        chk("contend_count", 64'(grants.size() >= 4), 1);
        if (grants.size() >= 4)
            for (int i = 0; i < 4; i++) chk($sformatf("contend_order%0d", i), 64'(grants[i]), 64'(i % 2));

        go_reset("reset2");
        mode = 1;
        repeat (30) cycle();
        chk("throughput", 64'(n_done), 10);

        go_reset("reset3");
        mode = 0;
        repeat (3000) cycle();

        for (int i = 0; i < 200 && !(inflight && !acc_dn); i++) cycle();
        chk("midreq_found", 64'(inflight && !acc_dn), 1);
        @(posedge clk);
        #2;
        chk("midreq_avalid", 64'(m_avalid), 1);
        go_reset("midreq");
        repeat (500) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
